// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store,
// sequencing req/ready -> mem_req/mem_gnt -> mem_rvalid and routing responses.
module mem_port_arbiter #(
  parameter bit          DATA_PRIORITY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic        imem_rvalid,
  output logic [31:0] imem_rdata,
  output logic        imem_err,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [1:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_ready,
  output logic        dmem_rvalid,
  output logic [31:0] dmem_rdata,
  output logic        dmem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        cpu_stall
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_WAIT_RESP,
    ST_ERR_RESP
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;    // 1 = dmem owns the transaction in flight
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [15:0] r_tcnt;

  logic        w_idle;
  logic        w_waiting;
  logic        w_sel_d;
  logic        w_sel_i;
  logic        w_misaligned;
  logic [3:0]  w_dbe;
  logic [31:0] w_dwdata;
  logic        w_resp_done;
  logic        w_timeout;
  logic        w_deliver;
  logic        w_unused_addr_bits;

  assign w_unused_addr_bits = &{1'b0, imem_addr[1:0]};

  assign w_idle    = (r_state == ST_IDLE);
  assign w_waiting = (r_state == ST_WAIT_GNT) || (r_state == ST_WAIT_RESP);
  assign w_sel_d   = dmem_req && (DATA_PRIORITY || !imem_req);
  assign w_sel_i   = imem_req && !w_sel_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_misaligned = 1'b0;
    w_dbe        = 4'b1111;
    w_dwdata     = dmem_wdata;
    case (dmem_size)
      2'd0: begin
        w_dbe    = 4'b0001 << dmem_addr[1:0];
        w_dwdata = {4{dmem_wdata[7:0]}};
      end
      2'd1: begin
        w_dbe        = dmem_addr[1] ? 4'b1100 : 4'b0011;
        w_dwdata     = {2{dmem_wdata[15:0]}};
        w_misaligned = dmem_addr[0];
      end
      2'd2:    w_misaligned = |dmem_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // A response in the last allowed cycle beats the timeout.
  assign w_resp_done = (r_state == ST_WAIT_RESP) && mem_rvalid;
  assign w_timeout   = TO_EN && w_waiting && (r_tcnt == TO_LAST) && !w_resp_done;
  assign w_deliver   = w_resp_done || w_timeout;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_d)      w_next = w_misaligned ? ST_ERR_RESP : ST_WAIT_GNT;
        else if (w_sel_i) w_next = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: begin
        if (w_timeout)    w_next = ST_IDLE;
        else if (mem_gnt) w_next = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: if (w_deliver) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && (w_sel_d || w_sel_i)) begin
        r_owner <= w_sel_d;
        r_we    <= w_sel_d && dmem_we;
        r_addr  <= w_sel_d ? {dmem_addr[31:2], 2'b00} : {imem_addr[31:2], 2'b00};
        r_be    <= w_sel_d ? w_dbe : 4'b1111;
        r_wdata <= w_sel_d ? w_dwdata : '0;
        r_tcnt  <= '0;
      end else if (w_waiting) begin
        r_tcnt  <= r_tcnt + 16'd1;
      end
    end
  end

  assign mem_req   = (r_state == ST_WAIT_GNT);
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = mem_req ? r_addr  : '0;
  assign mem_be    = mem_req ? r_be    : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;

  assign imem_ready  = w_idle && w_sel_i;
  assign dmem_ready  = w_idle && w_sel_d;

  assign imem_rvalid = w_deliver && !r_owner;
  assign imem_err    = w_timeout && !r_owner;
  assign imem_rdata  = (w_resp_done && !r_owner) ? mem_rdata : '0;

  assign dmem_rvalid = (w_deliver && r_owner) || (r_state == ST_ERR_RESP);
  assign dmem_err    = (w_timeout && r_owner) || (r_state == ST_ERR_RESP);
  assign dmem_rdata  = (w_resp_done && r_owner) ? mem_rdata : '0;

  assign cpu_stall = (imem_req || dmem_req || !w_idle) && !(imem_rvalid || dmem_rvalid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, stores, misalignment,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        imem_ready, imem_rvalid, imem_err;
  logic [31:0] imem_rdata;
  logic        dmem_req = 1'b0;
  logic        dmem_we = 1'b0;
  logic [1:0]  dmem_size = 2'd2;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_ready, dmem_rvalid, dmem_err;
  logic [31:0] dmem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'hFFFF_FFFF;
  logic        cpu_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  mis_size [3] = '{2'd2, 2'd1, 2'd3};
  logic [31:0] mis_addr [3] = '{32'h401, 32'h401, 32'h400};

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_imem_rvalid", 32'(imem_rvalid), 32'd0);
    check("rst_dmem_rvalid", 32'(dmem_rvalid), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Basic fetch: ready in 0, mem_req in 1, rvalid in 2
    next_cycle();
    imem_req = 1'b1; imem_addr = 32'h0000_0103;
    #1;
    check("f_ready", 32'(imem_ready), 32'd1);
    check("f_req0", 32'(mem_req), 32'd0);
    check("f_stall0", 32'(cpu_stall), 32'd1);
    next_cycle();
    imem_req = 1'b0; mem_gnt = 1'b1;
    #1;
    check("f_req1", 32'(mem_req), 32'd1);
    check("f_addr", mem_addr, 32'h0000_0100);
    check("f_be", 32'(mem_be), 32'hF);
    check("f_we", 32'(mem_we), 32'd0);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("f_req2", 32'(mem_req), 32'd0);
    check("f_rvalid", 32'(imem_rvalid), 32'd1);
    check("f_rdata", imem_rdata, 32'hDEAD_BEEF);
    check("f_err", 32'(imem_err), 32'd0);
    check("f_dmem_quiet", 32'(dmem_rvalid), 32'd0);
    check("f_stall2", 32'(cpu_stall), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("f_rvalid_off", 32'(imem_rvalid), 32'd0);
    check("f_rdata_off", imem_rdata, 32'h0);

    // Simultaneous requests: dmem first, then imem
    next_cycle();
    imem_req = 1'b1; imem_addr = 32'h0000_0040;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_size = 2'd2; dmem_addr = 32'h0000_0200;
    #1;
    check("p_dready", 32'(dmem_ready), 32'd1);
    check("p_iready", 32'(imem_ready), 32'd0);
    next_cycle();
    dmem_req = 1'b0; mem_gnt = 1'b1;
    #1;
    check("p_req_d", 32'(mem_req), 32'd1);
    check("p_addr_d", mem_addr, 32'h0000_0200);
    check("p_iready_busy", 32'(imem_ready), 32'd0);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    check("p_drvalid", 32'(dmem_rvalid), 32'd1);
    check("p_drdata", dmem_rdata, 32'h1111_2222);
    check("p_irvalid_quiet", 32'(imem_rvalid), 32'd0);
    check("p_irdata_quiet", imem_rdata, 32'h0);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("p_iready", 32'(imem_ready), 32'd1);
    check("p_req_gap", 32'(mem_req), 32'd0);
    next_cycle();
    imem_req = 1'b0; mem_gnt = 1'b1;
    #1;
    check("p_req_i", 32'(mem_req), 32'd1);
    check("p_addr_i", mem_addr, 32'h0000_0040);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
    #1;
    check("p_irvalid", 32'(imem_rvalid), 32'd1);
    check("p_irdata", imem_rdata, 32'h3333_4444);
    check("p_drvalid_quiet", 32'(dmem_rvalid), 32'd0);
    check("p_drdata_quiet", dmem_rdata, 32'h0);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;

    // Store byte 0xA5 at 0x303, grant on the second request cycle
    next_cycle();
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_size = 2'd0;
    dmem_addr = 32'h0000_0303; dmem_wdata = 32'h1234_56A5;
    #1;
    check("sb_ready", 32'(dmem_ready), 32'd1);
    next_cycle();
    dmem_req = 1'b0;
    #1;
    check("sb_req", 32'(mem_req), 32'd1);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_we", 32'(mem_we), 32'd1);
    check("sb_addr", mem_addr, 32'h0000_0300);
    next_cycle();
    mem_gnt = 1'b1;
    #1;
    check("sb_req_held", 32'(mem_req), 32'd1);
    check("sb_be_held", 32'(mem_be), 32'h8);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    #1;
    check("sb_rvalid", 32'(dmem_rvalid), 32'd1);
    check("sb_err", 32'(dmem_err), 32'd0);
    check("sb_req_off", 32'(mem_req), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;

    // Store half at 0x302
    next_cycle();
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_size = 2'd1;
    dmem_addr = 32'h0000_0302; dmem_wdata = 32'h0000_BEEF;
    #1;
    check("sh_ready", 32'(dmem_ready), 32'd1);
    next_cycle();
    dmem_req = 1'b0; mem_gnt = 1'b1;
    #1;
    check("sh_be", 32'(mem_be), 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_we", 32'(mem_we), 32'd1);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    #1;
    check("sh_rvalid", 32'(dmem_rvalid), 32'd1);
    next_cycle();
    mem_rvalid = 1'b0; dmem_we = 1'b0;

    // Misaligned: word@0x401, half@0x401, size 3
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      dmem_req = 1'b1; dmem_size = mis_size[k]; dmem_addr = mis_addr[k];
      #1;
      check($sformatf("mis%0d_ready", k), 32'(dmem_ready), 32'd1);
      check($sformatf("mis%0d_rv0", k), 32'(dmem_rvalid), 32'd0);
      next_cycle();
      dmem_req = 1'b0;
      #1;
      check($sformatf("mis%0d_req", k), 32'(mem_req), 32'd0);
      check($sformatf("mis%0d_rvalid", k), 32'(dmem_rvalid), 32'd1);
      check($sformatf("mis%0d_err", k), 32'(dmem_err), 32'd1);
      check($sformatf("mis%0d_rdata", k), dmem_rdata, 32'h0);
      next_cycle();
      #1;
      check($sformatf("mis%0d_req_after", k), 32'(mem_req), 32'd0);
      check($sformatf("mis%0d_rv_after", k), 32'(dmem_rvalid), 32'd0);
    end

    // Timeout with no grant: mem_req for 4 cycles, error in the 4th
    next_cycle();
    imem_req = 1'b1; imem_addr = 32'h0000_0500;
    #1;
    check("to_ready", 32'(imem_ready), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      imem_req = 1'b0;
      #1;
      check($sformatf("to_req_c%0d", c), 32'(mem_req), 32'd1);
      check($sformatf("to_rvalid_c%0d", c), 32'(imem_rvalid), 32'(c == 4));
      check($sformatf("to_err_c%0d", c), 32'(imem_err), 32'(c == 4));
    end
    check("to_rdata", imem_rdata, 32'h0);
    next_cycle();
    #1;
    check("to_req_drop", 32'(mem_req), 32'd0);
    check("to_rvalid_off", 32'(imem_rvalid), 32'd0);
    check("to_idle_stall", 32'(cpu_stall), 32'd0);

    // Response in the final allowed cycle completes normally
    next_cycle();
    dmem_req = 1'b1; dmem_size = 2'd2; dmem_addr = 32'h0000_0600;
    #1;
    check("tc_ready", 32'(dmem_ready), 32'd1);
    next_cycle();
    dmem_req = 1'b0; mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    next_cycle();
    #1;
    check("tc_rv_early", 32'(dmem_rvalid), 32'd0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("tc_rvalid", 32'(dmem_rvalid), 32'd1);
    check("tc_err", 32'(dmem_err), 32'd0);
    check("tc_rdata", dmem_rdata, 32'hCAFE_F00D);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("tc_rv_off", 32'(dmem_rvalid), 32'd0);
    check("tc_stall_off", 32'(cpu_stall), 32'd0);

    // Reset in WAIT_RESP, stray response, then a normal request
    next_cycle();
    imem_req = 1'b1; imem_addr = 32'h0000_0700;
    next_cycle();
    imem_req = 1'b0; mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    #1;
    check("rs_stall_before", 32'(cpu_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_req", 32'(mem_req), 32'd0);
    check("rs_irvalid", 32'(imem_rvalid), 32'd0);
    check("rs_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    #1;
    check("rs_stray_i", 32'(imem_rvalid), 32'd0);
    check("rs_stray_d", 32'(dmem_rvalid), 32'd0);
    check("rs_stray_rdata", imem_rdata, 32'h0);
    next_cycle();
    mem_rvalid = 1'b0;
    dmem_req = 1'b1; dmem_size = 2'd2; dmem_addr = 32'h0000_0800;
    #1;
    check("rs_new_ready", 32'(dmem_ready), 32'd1);
    next_cycle();
    dmem_req = 1'b0; mem_gnt = 1'b1;
    #1;
    check("rs_new_req", 32'(mem_req), 32'd1);
    check("rs_new_addr", mem_addr, 32'h0000_0800);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_0000;
    #1;
    check("rs_new_rvalid", 32'(dmem_rvalid), 32'd1);
    check("rs_new_rdata", dmem_rdata, 32'h5A5A_0000);
    next_cycle();
    mem_rvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
